// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank: default widths, flag layout and
// the flags reset value.
package reg_bank_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 2;
  localparam int DEF_NREG  = 1 << DEF_AW;

  // Bit positions inside the flags register {neg, carry, zero}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  // Zero flag set out of reset, matching the ALU's own reset flags
  localparam logic [2:0] FLAGS_RST = 3'b001;

  // Pack the ALU flag outputs into the flags register layout
  function automatic logic [2:0] pack_flags(input logic neg, input logic carry,
                                            input logic zero);
    logic [2:0] f;
    f         = '0;
    f[FLAG_N] = neg;
    f[FLAG_C] = carry;
    f[FLAG_Z] = zero;
    return f;
  endfunction

endpackage

// File: rtl/reg_bank_wb_pipe.sv
// One-entry pending stage that tracks the ALU write-back in flight, plus the
// bypass compare shared by both read ports.
module wb_pipe
  import reg_bank_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic          flag_en,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          p_valid,
  output logic [AW-1:0] p_addr,
  output logic          p_flag,
  output logic          hit_a,
  output logic          hit_b
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic          flag;
  } pend_t;

  pend_t pend;

  // Capture the issuing instruction's write-back intent every cycle; no stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend.valid <= wb_en;
      pend.addr  <= wb_addr;
      pend.flag  <= flag_en;
    end
  end

  assign p_valid = pend.valid;
  assign p_addr  = pend.addr;
  assign p_flag  = pend.flag;

  // A read hits the in-flight result only while a register write is pending
  always_comb begin
    hit_a = pend.valid && (rd_addr_a == pend.addr);
    hit_b = pend.valid && (rd_addr_b == pend.addr);
  end

endmodule

// File: rtl/reg_bank.sv
// Four-entry register bank feeding the ALU operands and absorbing its
// registered result and flags one cycle after issue, with read bypass.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW      // 2**AW must equal NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] val_a,
  output logic [WIDTH-1:0] val_b,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic             flag_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_neg,
  input  logic             imm_en,
  input  logic [AW-1:0]    imm_addr,
  input  logic [WIDTH-1:0] imm_data,
  output logic [2:0]       flags,
  output logic             wb_busy
);

  logic [NREG-1:0][WIDTH-1:0] regs;
  logic                       p_valid;
  logic [AW-1:0]              p_addr;
  logic                       p_flag;
  logic                       hit_a;
  logic                       hit_b;

  wb_pipe #(.AW(AW)) u_wb_pipe (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .flag_en  (flag_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .p_valid  (p_valid),
    .p_addr   (p_addr),
    .p_flag   (p_flag),
    .hit_a    (hit_a),
    .hit_b    (hit_b)
  );

  // Register writes: the immediate is the younger instruction, so it wins a
  // same-address collision with the pending ALU write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (imm_en && (imm_addr == AW'(i)))
          regs[i] <= imm_data;
        else if (p_valid && (p_addr == AW'(i)))
          regs[i] <= alu_result;
      end
    end
  end

  // Flags follow p_flag alone so compare-style ops can update without a write
  always_ff @(posedge clk) begin
    if (rst)
      flags <= FLAGS_RST;
    else if (p_flag)
      flags <= pack_flags(alu_neg, alu_carry, alu_zero);
  end

  // Operand reads: forward the in-flight ALU result, never the immediate
  always_comb begin
    val_a = hit_a ? alu_result : regs[rd_addr_a];
    val_b = hit_b ? alu_result : regs[rd_addr_b];
  end

  assign wb_busy = p_valid;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus a randomized run
// against an instruction-level reference model.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic [7:0] val_a, val_b;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic       flag_en;
  logic [7:0] alu_result;
  logic       alu_zero, alu_carry, alu_neg;
  logic       imm_en;
  logic [1:0] imm_addr;
  logic [7:0] imm_data;
  logic [2:0] flags;
  logic       wb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .val_a     (val_a),
    .val_b     (val_b),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .flag_en   (flag_en),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_neg   (alu_neg),
    .imm_en    (imm_en),
    .imm_addr  (imm_addr),
    .imm_data  (imm_data),
    .flags     (flags),
    .wb_busy   (wb_busy)
  );

  // Reference model: architectural registers/flags plus the list of issued
  // instructions whose ALU result has not yet returned.
  typedef struct {
    logic       wb;
    logic [1:0] addr;
    logic       fl;
  } issue_t;

  logic [7:0] mregs [4];
  logic [2:0] mflags;
  issue_t     inflight [$];

  function automatic logic [7:0] model_read(input logic [1:0] a);
    if (inflight.size() > 0 && inflight[0].wb && inflight[0].addr == a)
      return alu_result;
    return mregs[a];
  endfunction

  function automatic logic model_busy();
    return inflight.size() > 0 && inflight[0].wb;
  endfunction

  // Retire the returning instruction, then apply the immediate (younger),
  // then record the newly issued instruction.
  task automatic model_edge();
    issue_t n;
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 8'h00;
      mflags = 3'b001;
      inflight.delete();
    end else begin
      if (inflight.size() > 0) begin
        if (inflight[0].wb) mregs[inflight[0].addr] = alu_result;
        if (inflight[0].fl) mflags = {alu_neg, alu_carry, alu_zero};
        void'(inflight.pop_front());
      end
      if (imm_en) mregs[imm_addr] = imm_data;
      n.wb = wb_en; n.addr = wb_addr; n.fl = flag_en;
      inflight.push_back(n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; rd_addr_a = 0; rd_addr_b = 0; wb_en = 0; wb_addr = 0; flag_en = 0;
    alu_result = 0; alu_zero = 0; alu_carry = 0; alu_neg = 0;
    imm_en = 0; imm_addr = 0; imm_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
      #1;
      checks++;
      if (val_a !== 8'h00 || val_b !== 8'h00) begin
        errors++;
        $display("FAIL reset_read i=%0d: val_a=%h val_b=%h expected 00", i, val_a, val_b);
      end
    end
    checks++;
    if (flags !== 3'b001) begin
      errors++; $display("FAIL reset_flags: got %b expected 001", flags);
    end
    checks++;
    if (wb_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", wb_busy);
    end
  endtask

  task automatic test_immediate();
    imm_en = 1; imm_addr = 2; imm_data = 8'h5A; rd_addr_a = 2;
    #1;
    checks++;
    if (val_a !== 8'h00) begin
      errors++; $display("FAIL imm_no_bypass: got %h expected 00", val_a);
    end
    tick();
    imm_en = 0;
    #1;
    checks++;
    if (val_a !== 8'h5A) begin
      errors++; $display("FAIL imm_visible: got %h expected 5a", val_a);
    end
  endtask

  task automatic test_wb_bypass();
    wb_en = 1; wb_addr = 1;
    tick();
    wb_en = 0; alu_result = 8'h3C; rd_addr_b = 1; rd_addr_a = 2;
    #1;
    checks++;
    if (val_b !== 8'h3C || wb_busy !== 1'b1) begin
      errors++; $display("FAIL wb_bypass: val_b=%h busy=%b expected 3c/1", val_b, wb_busy);
    end
    checks++;
    if (val_a !== 8'h5A) begin
      errors++; $display("FAIL wb_bypass_other: val_a=%h expected 5a", val_a);
    end
    tick();
    alu_result = 8'h00;
    #1;
    checks++;
    if (val_b !== 8'h3C || wb_busy !== 1'b0) begin
      errors++; $display("FAIL wb_stored: val_b=%h busy=%b expected 3c/0", val_b, wb_busy);
    end
  endtask

  task automatic test_flags_only();
    flag_en = 1;
    tick();
    flag_en = 0; alu_carry = 1; alu_zero = 1; alu_neg = 0; alu_result = 8'hEE;
    rd_addr_a = 1; rd_addr_b = 2;
    #1;
    checks++;
    if (flags !== 3'b001 || val_a !== 8'h3C || val_b !== 8'h5A) begin
      errors++;
      $display("FAIL flags_n1: flags=%b a=%h b=%h expected 001/3c/5a", flags, val_a, val_b);
    end
    tick();
    alu_carry = 0; alu_zero = 0; alu_result = 8'h00;
    #1;
    checks++;
    if (flags !== 3'b011) begin
      errors++; $display("FAIL flags_only: got %b expected 011", flags);
    end
    checks++;
    if (val_a !== 8'h3C || val_b !== 8'h5A) begin
      errors++; $display("FAIL flags_regs: a=%h b=%h expected 3c/5a", val_a, val_b);
    end
  endtask

  task automatic test_collision();
    wb_en = 1; wb_addr = 3;
    tick();
    wb_en = 0; alu_result = 8'hAA; imm_en = 1; imm_addr = 3; imm_data = 8'h11;
    rd_addr_a = 3;
    #1;
    checks++;
    if (val_a !== 8'hAA) begin
      errors++; $display("FAIL collision_bypass: got %h expected aa", val_a);
    end
    tick();
    imm_en = 0; alu_result = 8'h00;
    #1;
    checks++;
    if (val_a !== 8'h11) begin
      errors++; $display("FAIL collision: got %h expected 11", val_a);
    end
  endtask

  task automatic test_reset_mid();
    imm_en = 1; imm_addr = 0; imm_data = 8'h77;
    tick();
    imm_en = 0; wb_en = 1; wb_addr = 0; flag_en = 1;
    tick();
    wb_en = 0; flag_en = 0; rst = 1; alu_result = 8'hFF;
    alu_neg = 1; alu_carry = 1; alu_zero = 0;
    tick();
    rst = 0; alu_neg = 0; alu_carry = 0; alu_result = 8'h00;
    rd_addr_a = 0; rd_addr_b = 3;
    #1;
    checks++;
    if (val_a !== 8'h00 || val_b !== 8'h00) begin
      errors++; $display("FAIL reset_mid_regs: a=%h b=%h expected 00/00", val_a, val_b);
    end
    checks++;
    if (flags !== 3'b001 || wb_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_state: flags=%b busy=%b expected 001/0", flags, wb_busy);
    end
  endtask

  task automatic test_back_to_back_random();
    idle_inputs();
    rst = 1;
    model_edge();
    tick();
    rst = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst        = ($urandom_range(0, 49) == 0);
      rd_addr_a  = 2'($urandom); rd_addr_b = 2'($urandom);
      wb_en      = 1'($urandom); wb_addr = 2'($urandom);
      flag_en    = 1'($urandom);
      alu_result = 8'($urandom);
      alu_zero   = 1'($urandom); alu_carry = 1'($urandom); alu_neg = 1'($urandom);
      imm_en     = ($urandom_range(0, 2) == 0);
      imm_addr   = 2'($urandom); imm_data = 8'($urandom);
      #1;
      checks++;
      if (val_a !== model_read(rd_addr_a) || val_b !== model_read(rd_addr_b)) begin
        errors++;
        $display("FAIL rand_read cyc=%0d: a=%h b=%h expected %h/%h", cyc, val_a, val_b,
                 model_read(rd_addr_a), model_read(rd_addr_b));
      end
      checks++;
      if (flags !== mflags || wb_busy !== model_busy()) begin
        errors++;
        $display("FAIL rand_state cyc=%0d: flags=%b busy=%b expected %b/%b", cyc, flags,
                 wb_busy, mflags, model_busy());
      end
      model_edge();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_wb_bypass();
    test_flags_only();
    test_collision();
    test_reset_mid();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
